corevx_loadunit: RTL and testbench
==================================

// Module: corevx_loadunit
// PURPOSE
//  Memory-access stage for loads, directly upstream of corevx_loadgen.
//  - Accepts one load request from execute.
//  - Issues a word-aligned bus read and captures the raw word.
//  - Drives offset, type and raw data into corevx_loadgen; returns its aligned/extended result plus fault flags to writeback.
//  - Misaligned and unknown-type loads never reach the bus.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles spent in ADDR+DATA before access fault; 0 disables timeout
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   asynchronous, active-high reset
//  req_valid        in   1   load request valid
//  req_ready        out  1   request accepted when valid&ready
//  req_address      in   32  byte address
//  req_loadtype     in   3   ld_type.svh encoding
//  m_address        out  32  bus address, bits [1:0] forced 0
//  m_read           out  1   bus read request
//  m_waitrequest    in   1   bus stall; read accepted when m_read & !m_waitrequest
//  m_readdatavalid  in   1   read data valid
//  m_readdata       in   32  read data
//  m_response       in   2   2'b00 OK; any other value is a bus error
//  lg_inwordoffset  out  2   to loadgen inwordOffset (latched address[1:0])
//  lg_loadtype      out  3   to loadgen loadType (latched)
//  lg_datain        out  32  to loadgen LoadGenDataIn (latched bus word)
//  lg_missaligned   in   1   from loadgen LoadMissaligned
//  lg_unknowntype   in   1   from loadgen LoadUnknownType
//  lg_dataout       in   32  from loadgen LoadGenDataOut
//  rsp_valid        out  1   result valid
//  rsp_ready        in   1   result consumed when valid&ready
//  rsp_data         out  32  loaded value; 0 whenever any fault flag is set
//  rsp_missaligned  out  1   misaligned-address fault
//  rsp_unknowntype  out  1   illegal load type
//  rsp_accessfault  out  1   bus error or timeout
// BEHAVIOUR
//  Reset values:
//  - State IDLE; all registers 0.
//  - m_read=0, rsp_valid=0, flags=0; req_ready=1.
//  - Async reset mid-transaction aborts immediately and drops m_read; the later bus response is discarded.
//  IDLE:
//  - req_ready=1.
//  - On req_valid: latch address and type, clear data reg and flags, go CHECK.
//  - req_ready=0 in every other state; no request is accepted while one is in flight.
//  CHECK (1 cycle): evaluate loadgen flags from the latched offset/type.
//  - If lg_unknowntype or lg_missaligned: copy both flags, go RESP (no bus access).
//  - Else: clear timeout counter, go ADDR.
//  ADDR:
//  - m_read=1, m_address={addr[31:2],2'b00}; both held stable while m_waitrequest=1.
//  - When !m_waitrequest, go DATA.
//  - m_readdatavalid in ADDR is ignored; data arrives no earlier than the cycle after acceptance.
//  DATA:
//  - m_read=0.
//  - On m_readdatavalid: latch m_readdata into lg_datain reg; set accessfault if m_response!=0; go RESP.
//  Timeout:
//  - Counter increments each cycle in ADDR or DATA.
//  - When counter==TIMEOUT_CYCLES-1 and the bus event has not occurred: set accessfault, go RESP.
//  - A bus event in that same cycle takes priority over the timeout.
//  - Late data after a timeout is ignored: m_readdatavalid is ignored outside DATA.
//  RESP:
//  - rsp_valid=1; outputs stable until rsp_ready.
//  - rsp_data = any flag ? 0 : lg_dataout (combinational through loadgen from registered inputs).
//  - On rsp_ready go IDLE; a new request can be accepted on the following cycle.
//  Latency:
//  - Aligned, zero-wait bus: accept at T0, CHECK T1, ADDR T2, readdatavalid T3, rsp_valid T4.
//  - Misaligned or unknown type: rsp_valid at T2.
//  - Throughput: one load per ≥5 cycles.
// TESTING
//  - LW addr 0x100, mem word 0xDEADBEEF, no wait -> m_address=0x100 at T2, rsp_data=0xDEADBEEF at T4, no flags.
//  - LB addr 0x103, word 0x80FF0102 -> rsp_data=0xFFFFFF80; LBU same -> 0x00000080; m_address=0x100.
//  - LW addr 0x102 -> rsp_valid at T2, rsp_missaligned=1, rsp_data=0, m_read never asserted; loadType 3'b111 -> rsp_unknowntype=1.
//  - LH addr 0x202, waitrequest held 3 cycles, m_response=2'b10 -> m_read held 4 cycles, rsp_accessfault=1, rsp_data=0.
//  - TIMEOUT_CYCLES=8, bus never answers -> rsp_accessfault at cycle T10; data arriving later ignored; next LW completes normally.
//  - rsp_ready low 5 cycles -> rsp_* stable, req_ready=0 throughout; async rst pulse in ADDR -> m_read=0 same cycle, state IDLE.

Source files
------------

// File: rtl/corevx_loadunit.sv
// corevx_loadunit: load memory-access stage that performs one word-aligned bus read per load
// and returns the corevx_loadgen aligned/extended result with fault flags to writeback.
module corevx_loadunit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_address,
    input  logic [2:0]  req_loadtype,
    output logic [31:0] m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic        m_readdatavalid,
    input  logic [31:0] m_readdata,
    input  logic [1:0]  m_response,
    output logic [1:0]  lg_inwordoffset,
    output logic [2:0]  lg_loadtype,
    output logic [31:0] lg_datain,
    input  logic        lg_missaligned,
    input  logic        lg_unknowntype,
    input  logic [31:0] lg_dataout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_missaligned,
    output logic        rsp_unknowntype,
    output logic        rsp_accessfault
);
    typedef enum logic [2:0] {IDLE, CHECK, ADDR, DATA, RESP} state_t;
    state_t state, state_n;
    logic [31:0] addr_q, data_q, cnt;
    logic [2:0]  type_q;
    logic        mis_q, unk_q, af_q, tmo;
    assign tmo = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // a bus event in the timeout cycle wins over the timeout
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = req_valid ? CHECK : IDLE;
            CHECK:   state_n = (lg_unknowntype || lg_missaligned) ? RESP : ADDR;
            ADDR:    state_n = !m_waitrequest ? DATA : tmo ? RESP : ADDR;
            DATA:    state_n = (m_readdatavalid || tmo) ? RESP : DATA;
            RESP:    state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            type_q <= '0;
            data_q <= '0;
            cnt    <= '0;
            mis_q  <= 1'b0;
            unk_q  <= 1'b0;
            af_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q <= req_address;
                    type_q <= req_loadtype;
                    data_q <= '0;
                    mis_q  <= 1'b0;
                    unk_q  <= 1'b0;
                    af_q   <= 1'b0;
                end
                CHECK: begin
                    mis_q <= lg_missaligned;
                    unk_q <= lg_unknowntype;
                    cnt   <= '0;
                end
                ADDR: begin
                    cnt <= cnt + 32'd1;
                    if (m_waitrequest && tmo) af_q <= 1'b1;
                end
                DATA: begin
                    cnt <= cnt + 32'd1;
                    if (m_readdatavalid) begin
                        data_q <= m_readdata;
                        af_q   <= |m_response;
                    end else if (tmo) af_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
    assign req_ready       = state == IDLE;
    assign m_read          = state == ADDR;
    assign m_address       = {addr_q[31:2], 2'b00};
    assign lg_inwordoffset = addr_q[1:0];
    assign lg_loadtype     = type_q;
    assign lg_datain       = data_q;
    assign rsp_valid       = state == RESP;
    assign rsp_missaligned = mis_q;
    assign rsp_unknowntype = unk_q;
    assign rsp_accessfault = af_q;
    assign rsp_data        = (mis_q || unk_q || af_q) ? 32'd0 : lg_dataout;
endmodule

// File: tb/tb_corevx_loadunit.sv
// tb_corevx_loadunit: randomized transaction-level check of corevx_loadunit against a
// behavioural loadgen and per-load timing model.
module tb_corevx_loadunit;
    localparam int TO = 8;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_ready;
    logic [31:0] req_address = '0;
    logic [2:0] req_loadtype = '0;
    logic [31:0] m_address, m_readdata = '0;
    logic m_read, m_waitrequest = 1'b0, m_readdatavalid = 1'b0;
    logic [1:0] m_response = '0, lg_inwordoffset;
    logic [2:0] lg_loadtype;
    logic [31:0] lg_datain, lg_dataout, rsp_data;
    logic lg_missaligned, lg_unknowntype;
    logic rsp_valid, rsp_ready = 1'b0, rsp_missaligned, rsp_unknowntype, rsp_accessfault;
    int ncmp = 0, nerr = 0;
    logic chk = 1'b0;
    logic e_req_ready, e_m_read, e_rsp_valid, e_mis, e_unk, e_af;
    logic [31:0] e_addr, e_data;
    int g_first, g_nread;
    logic [31:0] g_data;
    logic g_mis, g_unk, g_af;

    corevx_loadunit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_address(req_address), .req_loadtype(req_loadtype),
        .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
        .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata), .m_response(m_response),
        .lg_inwordoffset(lg_inwordoffset), .lg_loadtype(lg_loadtype), .lg_datain(lg_datain),
        .lg_missaligned(lg_missaligned), .lg_unknowntype(lg_unknowntype), .lg_dataout(lg_dataout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_missaligned(rsp_missaligned), .rsp_unknowntype(rsp_unknowntype),
        .rsp_accessfault(rsp_accessfault)
    );

    always #5 clk = ~clk;

    // returns {unknown, misaligned, data}; RISC-V funct3 load encoding
    function automatic logic [33:0] lg_model(input logic [2:0] t, input logic [1:0] o, input logic [31:0] w);
        logic [31:0] s;
        s = w >> {o, 3'b000};
        case (t)
            3'b000:  return {2'b00, {{24{s[7]}}, s[7:0]}};
            3'b001:  return {1'b0, o[0], {{16{s[15]}}, s[15:0]}};
            3'b010:  return {1'b0, |o, w};
            3'b100:  return {2'b00, 24'd0, s[7:0]};
            3'b101:  return {1'b0, o[0], 16'd0, s[15:0]};
            default: return {2'b10, 32'd0};
        endcase
    endfunction

    assign {lg_unknowntype, lg_missaligned, lg_dataout} = lg_model(lg_loadtype, lg_inwordoffset, lg_datain);

    task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
        ncmp++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) if (chk) begin
        cmp("req_ready", 32'(req_ready), 32'(e_req_ready));
        cmp("m_read", 32'(m_read), 32'(e_m_read));
        if (e_m_read) cmp("m_address", m_address, e_addr);
        cmp("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
        if (e_rsp_valid) begin
            cmp("rsp_data", rsp_data, e_data);
            cmp("rsp_missaligned", 32'(rsp_missaligned), 32'(e_mis));
            cmp("rsp_unknowntype", 32'(rsp_unknowntype), 32'(e_unk));
            cmp("rsp_accessfault", 32'(rsp_accessfault), 32'(e_af));
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            req_address = $urandom;
            req_loadtype = 3'($urandom);
            m_waitrequest = 1'($urandom);
            m_readdatavalid = 1'($urandom);
            m_readdata = $urandom;
            m_response = 2'($urandom);
            rsp_ready = 1'($urandom);
            e_req_ready = 1'b1; e_m_read = 1'b0; e_rsp_valid = 1'b0; chk = 1'b1;
            @(negedge clk);
        end
    endtask

    // W: cycles waitrequest is held; L: cycles from acceptance to data; H: cycles rsp_ready held low
    task automatic run_load(input logic [31:0] a, input logic [2:0] ty, input logic [31:0] w,
                            input int W, input int L, input logic [1:0] rs, input logic na, input int H);
        logic [33:0] x;
        logic pre, to, ea, ev, dw;
        int rt, mr;
        x = lg_model(ty, a[1:0], w);
        pre = x[33] | x[32];
        to = !pre && (na || W + L > TO - 1);
        rt = pre ? 2 : to ? 2 + TO : 3 + W + L;
        mr = pre ? 0 : (W >= TO ? TO : W + 1);
        ea = !pre && (to || rs != 2'b00);
        g_first = -1;
        g_nread = 0;
        for (int t = 0; t <= rt + H; t++) begin
            @(posedge clk); #1;
            ev = !pre && !to && t == 2 + W + L;
            dw = !pre && t > 2 + W && t < rt;
            req_valid = t == 0 ? 1'b1 : 1'($urandom);
            req_address = t == 0 ? a : $urandom;
            req_loadtype = t == 0 ? ty : 3'($urandom);
            m_waitrequest = (t >= 2 && t < 2 + W) ? 1'b1 : (t == 2 + W) ? 1'b0 : 1'($urandom);
            m_readdatavalid = ev ? 1'b1 : dw ? 1'b0 : 1'($urandom);
            m_readdata = ev ? w : $urandom;
            m_response = ev ? rs : 2'($urandom);
            rsp_ready = t == rt + H ? 1'b1 : t >= rt ? 1'b0 : 1'($urandom);
            e_req_ready = t == 0;
            e_m_read = !pre && t >= 2 && t < 2 + mr;
            e_addr = {a[31:2], 2'b00};
            e_rsp_valid = t >= rt;
            e_data = (pre || ea) ? 32'd0 : x[31:0];
            e_mis = x[32]; e_unk = x[33]; e_af = ea;
            chk = 1'b1;
            @(negedge clk);
            if (m_read) g_nread++;
            if (rsp_valid && g_first < 0) begin
                g_first = t; g_data = rsp_data;
                g_mis = rsp_missaligned; g_unk = rsp_unknowntype; g_af = rsp_accessfault;
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cmp("reset req_ready", 32'(req_ready), 32'd1);
        cmp("reset m_read", 32'(m_read), 32'd0);
        cmp("reset rsp_valid", 32'(rsp_valid), 32'd0);
        cmp("reset flags", {29'd0, rsp_missaligned, rsp_unknowntype, rsp_accessfault}, 32'd0);
        rst = 1'b0;
        idle(2);

        run_load(32'h100, 3'b010, 32'hDEADBEEF, 0, 1, 2'b00, 1'b0, 0);
        cmp("LW latency", 32'(g_first), 32'd4);
        cmp("LW data", g_data, 32'hDEADBEEF);
        cmp("LW reads", 32'(g_nread), 32'd1);
        run_load(32'h103, 3'b000, 32'h80FF0102, 0, 1, 2'b00, 1'b0, 0);
        cmp("LB data", g_data, 32'hFFFFFF80);
        run_load(32'h103, 3'b100, 32'h80FF0102, 0, 1, 2'b00, 1'b0, 0);
        cmp("LBU data", g_data, 32'h00000080);
        run_load(32'h102, 3'b010, 32'h11223344, 0, 1, 2'b00, 1'b0, 0);
        cmp("misaligned latency", 32'(g_first), 32'd2);
        cmp("misaligned flag", 32'(g_mis), 32'd1);
        cmp("misaligned reads", 32'(g_nread), 32'd0);
        cmp("misaligned data", g_data, 32'd0);
        run_load(32'h104, 3'b111, 32'h11223344, 0, 1, 2'b00, 1'b0, 0);
        cmp("unknown flag", 32'(g_unk), 32'd1);
        run_load(32'h202, 3'b001, 32'h80FF0102, 3, 1, 2'b10, 1'b0, 0);
        cmp("bus error reads", 32'(g_nread), 32'd4);
        cmp("bus error flag", 32'(g_af), 32'd1);
        cmp("bus error data", g_data, 32'd0);
        run_load(32'h400, 3'b010, 32'h55555555, 0, 1, 2'b00, 1'b1, 0);
        cmp("timeout latency", 32'(g_first), 32'd10);
        cmp("timeout flag", 32'(g_af), 32'd1);
        run_load(32'h404, 3'b010, 32'hCAFEF00D, 0, 1, 2'b00, 1'b0, 0);
        cmp("after timeout data", g_data, 32'hCAFEF00D);
        cmp("after timeout latency", 32'(g_first), 32'd4);
        run_load(32'h106, 3'b101, 32'h80010000, 1, 2, 2'b00, 1'b0, 5);
        cmp("LHU held data", g_data, 32'h00008001);

        // async reset while the read is stalled in ADDR
        @(posedge clk); #1;
        req_valid = 1'b1; req_address = 32'h300; req_loadtype = 3'b010;
        m_waitrequest = 1'b1; m_readdatavalid = 1'b0; rsp_ready = 1'b0;
        e_req_ready = 1'b1; e_m_read = 1'b0; e_rsp_valid = 1'b0; e_addr = 32'h300; chk = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            e_req_ready = 1'b0;
            e_m_read = t >= 2;
        end
        @(negedge clk); #2;
        chk = 1'b0;
        rst = 1'b1;
        #1;
        cmp("rst m_read", 32'(m_read), 32'd0);
        cmp("rst req_ready", 32'(req_ready), 32'd1);
        cmp("rst rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b1; m_readdata = 32'h12345678; m_response = 2'b00;
        e_req_ready = 1'b1; e_m_read = 1'b0; e_rsp_valid = 1'b0; chk = 1'b1;
        @(negedge clk);
        idle(2);
        run_load(32'h500, 3'b010, 32'h0BADF00D, 1, 1, 2'b00, 1'b0, 0);
        cmp("after reset data", g_data, 32'h0BADF00D);

        for (int i = 0; i < 250; i++) begin
            int W, r;
            r = $urandom_range(0, 15);
            W = r == 0 ? 9 : r % 4;
            run_load($urandom, 3'($urandom), $urandom, W, $urandom_range(1, 4),
                     $urandom_range(0, 7) == 0 ? 2'($urandom_range(1, 3)) : 2'b00,
                     $urandom_range(0, 15) == 0, $urandom_range(0, 3));
            idle($urandom_range(0, 2));
        end
        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
